// File: rtl/i_cache.sv
// i_cache: direct-mapped instruction cache, 2**INDEX_BITS lines of 4 x 16-bit words.
//
// Ports:
//   Clk, Reset_N        clock (rising edge) and asynchronous active-low reset
//   i_readM, i_address  CPU fetch request (level) and word address
//   i_data, i_ready     fetched word and same-cycle completion (hit)
//   flush               invalidate every line at the next edge
//   mem_readM           line-fill request, held high for the whole fill
//   mem_address         line-aligned fill address (zero when not filling)
//   mem_ready, mem_data memory returns the 64-bit line; word k on [16k+15:16k]
//   num_hit, num_miss   free-running 16-bit hit/miss counters (wrap)
//   dbg_state           1 while the controller is in FILL
//
// Handshake: a fetch completes in the cycle i_ready=1 (combinational on a hit).
// A miss moves to FILL, where mem_readM stays high until the edge that sees
// mem_ready=1; that edge installs the line and the unchanged request then hits.
module i_cache #(
    parameter int INDEX_BITS = 2
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        i_readM,
    input  logic [15:0] i_address,
    output logic [15:0] i_data,
    output logic        i_ready,
    input  logic        flush,
    output logic        mem_readM,
    output logic [15:0] mem_address,
    input  logic        mem_ready,
    input  logic [63:0] mem_data,
    output logic [15:0] num_hit,
    output logic [15:0] num_miss,
    output logic        dbg_state
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 14 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [TAG_BITS-1:0]   tag_d  [LINES];
    logic [63:0]           line_q [LINES];
    logic [63:0]           line_d [LINES];
    logic [13:0]           addr_q, addr_d;      // latched line address, bits [15:2]
    logic [15:0]           num_hit_q, num_hit_d;
    logic [15:0]           num_miss_q, num_miss_d;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;

    assign offset     = i_address[1:0];
    assign index      = i_address[INDEX_BITS+1:2];
    assign tag        = i_address[15:INDEX_BITS+2];
    assign fill_index = addr_q[INDEX_BITS-1:0];
    assign fill_tag   = addr_q[13:INDEX_BITS];

    assign hit = i_readM && valid_q[index] && (tag_q[index] == tag) && (state_q == IDLE);

    assign i_ready     = hit;
    assign i_data      = hit ? line_q[index][{offset, 4'b0000} +: 16] : 16'h0000;
    assign mem_readM   = (state_q == FILL);
    assign mem_address = (state_q == FILL) ? {addr_q, 2'b00} : 16'h0000;
    assign num_hit     = num_hit_q;
    assign num_miss    = num_miss_q;
    assign dbg_state   = (state_q == FILL);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        line_d     = line_q;
        addr_d     = addr_q;
        num_hit_d  = hit ? num_hit_q + 16'd1 : num_hit_q;
        num_miss_d = num_miss_q;

        // Flush is applied first so a fill completing on the same edge
        // still leaves its own line valid.
        if (flush) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (i_readM && !hit) begin
                    state_d    = FILL;
                    addr_d     = i_address[15:2];
                    num_miss_d = num_miss_q + 16'd1;
                end
            end
            FILL: begin
                // Request inputs are ignored here; only the latched address matters.
                if (mem_ready) begin
                    state_d             = IDLE;
                    valid_d[fill_index] = 1'b1;
                    tag_d[fill_index]   = fill_tag;
                    line_d[fill_index]  = mem_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            num_hit_q  <= '0;
            num_miss_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            num_hit_q  <= num_hit_d;
            num_miss_q <= num_miss_d;
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge Clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

endmodule
